// File: rtl/bit_reverse_collect.sv
// Serial-to-parallel frame collector: bit k of each frame lands at index bitrev(k).
// A one-frame holding register lets the next frame assemble while the current one drains.
module bit_reverse_collect #(
  parameter int N     = 256,
  parameter int LOG2N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         frame_err
);

  // N is a power of two, so the terminal count is all ones.
  localparam logic [LOG2N-1:0] CNT_MAX = {LOG2N{1'b1}};

  typedef enum logic {
    S_COLLECT,
    S_WAIT
  } state_t;

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] rev_idx;
  logic [N-1:0]     asm_buf;
  logic [N-1:0]     merged;
  logic             accept;
  logic             drain;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Assembly buffer with the current beat already merged in, so a completing
  // beat can be forwarded straight to out_data on the same edge.
  always_comb begin
    rev_idx         = bitrev(cnt);
    merged          = asm_buf;
    merged[rev_idx] = in_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_COLLECT;
      cnt       <= '0;
      asm_buf   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (drain) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (cnt == CNT_MAX) begin
              cnt       <= '0;
              frame_err <= !in_last;
              if (!out_valid || out_ready) begin
                out_data  <= merged;
                out_valid <= 1'b1;
                asm_buf   <= '0;
              end else begin
                asm_buf  <= merged;
                state    <= S_WAIT;
                in_ready <= 1'b0;
              end
            end else if (in_last) begin
              cnt       <= '0;
              asm_buf   <= '0;
              frame_err <= 1'b1;
            end else begin
              cnt     <= cnt + 1'b1;
              asm_buf <= merged;
            end
          end
        end
        S_WAIT: begin
          if (drain) begin
            out_data  <= asm_buf;
            out_valid <= 1'b1;
            asm_buf   <= '0;
            state     <= S_COLLECT;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= S_COLLECT;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_reverse_collect.sv
// Directed + randomized bench for bit_reverse_collect; expected frames come from
// an index-reversal model computed with plain integer arithmetic.
module tb_bit_reverse_collect;

  localparam int N     = 256;
  localparam int LOG2N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         frame_err;

  int n_vec = 0;
  int n_err = 0;
  int err_pulses;
  logic ov_seen;

  bit_reverse_collect #(.N(N), .LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] exp_frame(input logic [N-1:0] nat);
    logic [N-1:0] r;
    int x;
    int p;
    r = '0;
    for (int k = 0; k < N; k++) begin
      x = k;
      p = 0;
      for (int i = 0; i < LOG2N; i++) begin
        p = p * 2 + x % 2;
        x = x / 2;
      end
      r[p] = nat[k];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd_frame();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_err === 1'b1) err_pulses++;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk1("in_ready_wait", in_ready, 1'b1);
  endtask

  // Sends nbeats bits of nat in natural order with random idle gaps.
  task automatic send(input logic [N-1:0] nat, input int nbeats, input bit mark_last);
    wait_ready();
    err_pulses = 0;
    ov_seen    = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      while ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
        tick();
        if (out_valid === 1'b1) ov_seen = 1'b1;
      end
      in_valid = 1'b1;
      in_bit   = nat[k];
      in_last  = mark_last && (k == nbeats - 1);
      tick();
      if (k < nbeats - 1 && out_valid === 1'b1) ov_seen = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [N-1:0] f;
    logic [N-1:0] f1;
    logic [N-1:0] f2;
    logic [N-1:0] c;

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    err_pulses = 0;
    repeat (3) tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chkd("rst_out_data", out_data, '0);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("rel_in_ready", in_ready, 1'b1);
    chk1("rel_out_valid", out_valid, 1'b0);

    // single bit at k=1 lands at index 128
    out_ready = 1'b1;
    f = '0; f[1] = 1'b1;
    send(f, N, 1'b1);
    chk1("t1_ov_early", ov_seen, 1'b0);
    chk1("t1_out_valid", out_valid, 1'b1);
    c = '0; c[128] = 1'b1;
    chkd("t1_bit128", out_data, c);
    chkd("t1_model", out_data, exp_frame(f));
    chki("t1_err_pulses", err_pulses, 0);
    tick();
    chk1("t1_drained", out_valid, 1'b0);

    // bit k = k[0]: upper half set
    for (int k = 0; k < N; k++) f[k] = 1'(k % 2);
    send(f, N, 1'b1);
    chkd("t2_lsb_const", out_data, {{(N/2){1'b1}}, {(N/2){1'b0}}});
    chkd("t2_lsb_model", out_data, exp_frame(f));
    tick();
    // bit k = k[7]: odd indices set
    for (int k = 0; k < N; k++) f[k] = 1'((k / 128) % 2);
    send(f, N, 1'b1);
    for (int i = 0; i < N; i++) c[i] = 1'(i % 2);
    chkd("t2_msb_const", out_data, c);
    chkd("t2_msb_model", out_data, exp_frame(f));
    tick();

    // back-pressure across two frames
    out_ready = 1'b0;
    f1 = rnd_frame();
    send(f1, N, 1'b1);
    chk1("t3_f1_valid", out_valid, 1'b1);
    chkd("t3_f1_data", out_data, exp_frame(f1));
    f2 = rnd_frame();
    send(f2, N, 1'b1);
    chk1("t3_stall_ready", in_ready, 1'b0);
    chk1("t3_stall_valid", out_valid, 1'b1);
    chkd("t3_stall_data", out_data, exp_frame(f1));
    repeat (3) tick();
    chkd("t3_hold_data", out_data, exp_frame(f1));
    chk1("t3_hold_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkd("t3_f2_data", out_data, exp_frame(f2));
    chk1("t3_f2_valid", out_valid, 1'b1);
    chk1("t3_resume_ready", in_ready, 1'b1);
    tick();
    chkd("t3_f2_hold", out_data, exp_frame(f2));
    out_ready = 1'b1;
    tick();
    chk1("t3_drained", out_valid, 1'b0);

    // early in_last at k=100
    send(rnd_frame(), 101, 1'b1);
    chki("t4_err_pulses", err_pulses, 1);
    chk1("t4_ov_early", ov_seen, 1'b0);
    repeat (3) tick();
    chk1("t4_no_frame", out_valid, 1'b0);
    chki("t4_err_once", err_pulses, 1);
    f = rnd_frame();
    send(f, N, 1'b1);
    chkd("t4_next_data", out_data, exp_frame(f));
    chki("t4_next_err", err_pulses, 0);
    tick();

    // missing in_last at k=255
    f = rnd_frame();
    send(f, N, 1'b0);
    chk1("t5_out_valid", out_valid, 1'b1);
    chk1("t5_frame_err", frame_err, 1'b1);
    chkd("t5_data", out_data, exp_frame(f));
    tick();
    chk1("t5_err_clear", frame_err, 1'b0);
    chki("t5_err_once", err_pulses, 1);

    // reset mid-frame at k=150
    send(rnd_frame(), 150, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk1("t6_rst_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("t6_rel_ready", in_ready, 1'b1);
    repeat (3) tick();
    chk1("t6_no_frame", out_valid, 1'b0);
    f = rnd_frame();
    send(f, N, 1'b1);
    chk1("t6_out_valid", out_valid, 1'b1);
    chkd("t6_data", out_data, exp_frame(f));
    chki("t6_err", err_pulses, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
